// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST argmax classifier stage.
//   state_e            : FSM encoding (IDLE / SCAN / DONE)
//   MNIST_NUM_CLASSES  : default number of class scores
//   MNIST_DATA_W       : default signed score width
//   MNIST_IDX_W        : default class index width
package mnist_pkg;

  localparam int MNIST_NUM_CLASSES = 10;
  localparam int MNIST_DATA_W      = 32;
  localparam int MNIST_IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mnist_argmax_cmp.sv
// Combinational signed compare/select for one argmax step.
//   cand, cand_idx   : candidate score and its class index
//   best, best_idx   : running best score and its class index
//   new_best/new_idx : updated running best
//   take             : candidate strictly greater than best (ties keep best)
module mnist_argmax_cmp
  import mnist_pkg::*;
#(
  parameter int DATA_W = MNIST_DATA_W,
  parameter int IDX_W  = MNIST_IDX_W
) (
  input  logic signed [DATA_W-1:0] cand,
  input  logic        [IDX_W-1:0]  cand_idx,
  input  logic signed [DATA_W-1:0] best,
  input  logic        [IDX_W-1:0]  best_idx,
  output logic signed [DATA_W-1:0] new_best,
  output logic        [IDX_W-1:0]  new_idx,
  output logic                     take
);

  assign take     = (cand > best);
  assign new_best = take ? cand : best;
  assign new_idx  = take ? cand_idx : best_idx;

endmodule

// File: rtl/mnist_argmax.sv
// MNIST classifier output stage: snapshots NUM_CLASSES signed scores on start,
// scans them one per cycle for the maximum (lowest index wins ties) and
// presents the winning digit and score with a valid/ready handshake.
//   clk, reset (sync, active-high)
//   start, scores_in         : snapshot request and flat score bus
//   busy, out_valid          : scanning/holding result, result valid
//   out_ready                : consumer accept
//   digit, max_score, margin : result (margin = best - second best)
// Optional feature: define MNIST_ARGMAX_MARGIN_EN to track the second-best
// score and report margin; otherwise margin is tied to 0.
module mnist_argmax
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = MNIST_NUM_CLASSES,
  parameter int DATA_W      = MNIST_DATA_W,
  parameter int IDX_W       = MNIST_IDX_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_CLASSES*DATA_W-1:0]   scores_in,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_W-1:0]                digit,
  output logic signed [DATA_W-1:0]        max_score,
  output logic signed [DATA_W:0]          margin
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] snap_q [NUM_CLASSES];
  logic                     snap_we;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic signed [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W-1:0]         digit_q, digit_d;
  logic signed [DATA_W-1:0] max_q, max_d;

  logic signed [DATA_W-1:0] cand;
  logic signed [DATA_W-1:0] cmp_best;
  logic [IDX_W-1:0]         cmp_idx;
  logic                     cmp_take;

`ifdef MNIST_ARGMAX_MARGIN_EN
  // Second-best starts at the most negative value so any real score can fill it.
  localparam logic signed [DATA_W-1:0] SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W-1:0] second_q, second_d;
  logic signed [DATA_W:0]   margin_q, margin_d;
`endif

  assign cand = snap_q[ptr_q];

  mnist_argmax_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .cand     (cand),
    .cand_idx (ptr_q),
    .best     (best_q),
    .best_idx (best_idx_q),
    .new_best (cmp_best),
    .new_idx  (cmp_idx),
    .take     (cmp_take)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    max_d      = max_q;
    snap_we    = 1'b0;
`ifdef MNIST_ARGMAX_MARGIN_EN
    second_d   = second_q;
    margin_d   = margin_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_we    = 1'b1;
          best_d     = scores_in[DATA_W-1:0];
          best_idx_d = '0;
          ptr_d      = IDX_W'(1);
`ifdef MNIST_ARGMAX_MARGIN_EN
          second_d   = SCORE_MIN;
`endif
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        best_d     = cmp_best;
        best_idx_d = cmp_idx;
`ifdef MNIST_ARGMAX_MARGIN_EN
        // A new leader demotes the old best; otherwise the candidate may still
        // beat the current runner-up.
        if (cmp_take)
          second_d = best_q;
        else if (cand > second_q)
          second_d = cand;
`endif
        if (ptr_q == LAST_IDX) begin
          state_d = ST_DONE;
          digit_d = cmp_idx;
          max_d   = cmp_best;
`ifdef MNIST_ARGMAX_MARGIN_EN
          // One extra bit keeps best - second from overflowing.
          margin_d = {cmp_best[DATA_W-1], cmp_best} - {second_d[DATA_W-1], second_d};
`endif
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
      max_q      <= '0;
`ifdef MNIST_ARGMAX_MARGIN_EN
      second_q   <= '0;
      margin_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
`ifdef MNIST_ARGMAX_MARGIN_EN
      second_q   <= second_d;
      margin_q   <= margin_d;
`endif
    end
  end

  // Snapshot needs no reset: it is only read after being loaded by start.
  always_ff @(posedge clk) begin
    if (snap_we) begin
      for (int k = 0; k < NUM_CLASSES; k++)
        snap_q[k] <= scores_in[k*DATA_W +: DATA_W];
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign digit     = digit_q;
  assign max_score = max_q;
`ifdef MNIST_ARGMAX_MARGIN_EN
  assign margin    = margin_q;
`else
  assign margin    = '0;
`endif

endmodule

// File: tb/tb_mnist_argmax.sv
module tb_mnist_argmax;

  localparam int NC = 10;
  localparam int DW = 32;
  localparam int IW = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [NC*DW-1:0]      scores_in;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [IW-1:0]         digit;
  logic signed [DW-1:0]  max_score;
  logic signed [DW:0]    margin;

  mnist_argmax #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .scores_in (scores_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit     (digit),
    .max_score (max_score),
    .margin    (margin)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic signed [DW-1:0] sc [NC];
  logic [IW-1:0]        exp_digit;
  logic signed [DW-1:0] exp_max;
  logic signed [DW:0]   exp_margin;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: maximum value, lowest index holding it, and the largest of the
  // remaining scores (one instance of the winner removed) for the margin.
  task automatic model();
    longint mx, sec, mg;
    int idx;
    mx = sc[0];
    for (int k = 1; k < NC; k++) if (longint'(sc[k]) > mx) mx = sc[k];
    idx = -1;
    for (int k = 0; k < NC; k++) if (idx < 0 && longint'(sc[k]) == mx) idx = k;
    sec = -(longint'(1) << 40);
    for (int k = 0; k < NC; k++) if (k != idx && longint'(sc[k]) > sec) sec = sc[k];
    mg = mx - sec;
    exp_digit = IW'(idx);
    exp_max   = DW'(mx);
`ifdef MNIST_ARGMAX_MARGIN_EN
    exp_margin = mg[DW:0];
`else
    exp_margin = '0;
`endif
  endtask

  task automatic drive_scores();
    for (int k = 0; k < NC; k++) scores_in[k*DW +: DW] = sc[k];
  endtask

  task automatic start_txn();
    drive_scores();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag);
    model();
    check({tag, "_valid"},  64'(out_valid), 64'(1));
    check({tag, "_digit"},  64'(digit), 64'(exp_digit));
    check({tag, "_max"},    64'(max_score), 64'(exp_max));
    check({tag, "_margin"}, 64'(margin), 64'(exp_margin));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_acc_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_acc_busy"},  64'(busy), 64'(0));
  endtask

  task automatic rand_scores(input bit narrow);
    for (int k = 0; k < NC; k++)
      sc[k] = narrow ? DW'($urandom_range(0, 6)) - 3 : $urandom;
  endtask

  initial begin
    int n;
    logic [IW-1:0] d_hold;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; scores_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_valid",  64'(out_valid), 64'(0));
    check("rst_digit",  64'(digit), 64'(0));
    check("rst_max",    64'(max_score), 64'(0));
    check("rst_margin", 64'(margin), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Ties resolve toward the lower index; fixed latency.
    sc = '{3, -7, 12, 0, 5, 12, -1, 8, 2, 4};
    start_txn();
    check("t1_busy",  64'(busy), 64'(1));
    check("t1_early", 64'(out_valid), 64'(0));
    wait_valid(n);
    check("t1_latency", 64'(n), 64'(NC - 1));
    check("t1_digit_lit", 64'(digit), 64'(2));
    check("t1_max_lit",   64'(max_score), 64'(12));
    check_result("t1");
    accept("t1");

    // Signed extremes, maximum in the last class.
    for (int k = 0; k < NC; k++) sc[k] = 32'h8000_0000;
    sc[NC-1] = -1;
    start_txn();
    wait_valid(n);
    check("t2_digit_lit", 64'(digit), 64'(NC - 1));
    check("t2_max_lit",   64'(max_score), 64'(-1));
    check_result("t2");
    accept("t2");

    // Result held while the consumer stalls.
    rand_scores(1'b0);
    start_txn();
    wait_valid(n);
    d_hold = digit;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 64'(out_valid), 64'(1));
      check("t3_hold_digit", 64'(digit), 64'(d_hold));
    end
    check_result("t3");
    accept("t3");

    // Start mid-scan with different scores is ignored.
    rand_scores(1'b0);
    start_txn();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) scores_in[k*DW +: DW] = $urandom;
    scores_in[5*DW +: DW] = 32'h7fff_ffff;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NC; k++) scores_in[k*DW +: DW] = $urandom;
    wait_valid(n);
    check("t4_latency", 64'(n), 64'(NC - 5));
    check_result("t4");
    accept("t4");

    // Reset in scan cycle 4 wins, then a clean transaction.
    rand_scores(1'b0);
    start_txn();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_busy",   64'(busy), 64'(0));
    check("t5_valid",  64'(out_valid), 64'(0));
    check("t5_digit",  64'(digit), 64'(0));
    check("t5_max",    64'(max_score), 64'(0));
    check("t5_margin", 64'(margin), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("t5_idle", 64'(busy), 64'(0));
    rand_scores(1'b0);
    start_txn();
    wait_valid(n);
    check("t5_latency", 64'(n), 64'(NC - 1));
    check_result("t5");
    accept("t5");

    // Back-to-back: start the cycle right after acceptance.
    rand_scores(1'b1);
    start_txn();
    wait_valid(n);
    check_result("t6a");
    accept("t6a");
    rand_scores(1'b1);
    sc[0] = 100;
    start_txn();
    wait_valid(n);
    check("t6_latency", 64'(n), 64'(NC - 1));
    check("t6_digit_lit", 64'(digit), 64'(0));
    check_result("t6b");
    // Start on the accepting edge is ignored.
    rand_scores(1'b0);
    drive_scores();
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check("t6_coinc_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("t6_coinc_idle", 64'(busy), 64'(0));

    // Randomised transactions, half with narrow ranges to force ties.
    for (int t = 0; t < 12; t++) begin
      rand_scores(t[0]);
      start_txn();
      wait_valid(n);
      check("rnd_latency", 64'(n), 64'(NC - 1));
      check_result("rnd");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      accept("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
